// File: rtl/gpio_serial_loader.sv
// Serial configuration loader for the user-project GPIO pad control chain.
// Optional macro GPIO_SERIAL_LOADER_RT_DIV_EN adds a run-time clk_div port.
module gpio_serial_loader #(
  parameter int unsigned NUM_PADS = 38,
  parameter int unsigned CFG_BITS = 13,
  parameter int unsigned CLK_DIV  = 4
) (
  input  logic                        clock,
  input  logic                        resetb,
`ifdef GPIO_SERIAL_LOADER_RT_DIV_EN
  input  logic [7:0]                  clk_div,
`endif
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(NUM_PADS)-1:0] cfg_idx,
  input  logic [CFG_BITS-1:0]         cfg_data,
  output logic                        serial_clock,
  output logic                        serial_data,
  output logic                        serial_load,
  output logic                        serial_resetn
);

  localparam int unsigned IW = $clog2(NUM_PADS);
  localparam int unsigned BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
`ifdef GPIO_SERIAL_LOADER_RT_DIV_EN
  localparam int unsigned TW = 9;
`else
  localparam int unsigned TW = $clog2(2 * CLK_DIV) + 1;
`endif
  localparam logic [IW-1:0] LastPad = IW'(NUM_PADS - 1);
  localparam logic [BW-1:0] LastBit = BW'(CFG_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StChainRst,
    StFetch,
    StWait,
    StShiftLo,
    StShiftHi,
    StLoad,
    StFinish
  } state_e;

  state_e state_q, state_d;

  logic [TW-1:0]       timer_q, timer_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CFG_BITS-1:0] sr_q, sr_d;
  logic                timer_done;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic sclk_q, sclk_d;
  logic sdat_q, sdat_d;
  logic load_q, load_d;
  logic srn_q, srn_d;

  // half: half-period in force for the running sequence; half_req: value taken on start
  logic [TW-1:0] half, half_req;

`ifdef GPIO_SERIAL_LOADER_RT_DIV_EN
  logic [TW-1:0] half_q, half_d;

  assign half_req = (clk_div == 8'd0) ? TW'(1) : TW'(clk_div);
  assign half     = half_q;

  always_comb begin
    half_d = half_q;
    if (state_q == StIdle && start) begin
      half_d = half_req;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      half_q <= TW'(1);
    end else begin
      half_q <= half_d;
    end
  end
`else
  assign half     = TW'(CLK_DIV);
  assign half_req = TW'(CLK_DIV);
`endif

  // State register
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      timer_q <= '0;
      bit_q   <= '0;
      idx_q   <= LastPad;
      sr_q    <= '0;
    end else begin
      timer_q <= timer_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
    end
  end

  assign timer_done = (timer_q == '0);

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    timer_d = timer_done ? timer_q : timer_q - TW'(1);
    bit_d   = bit_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StChainRst;
          timer_d = (half_req << 1) - TW'(1);
          idx_d   = LastPad;
        end
      end
      StChainRst: begin
        if (timer_done) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        state_d = StWait;
      end
      StWait: begin
        sr_d    = cfg_data;
        bit_d   = LastBit;
        timer_d = half - TW'(1);
        state_d = StShiftLo;
      end
      StShiftLo: begin
        if (timer_done) begin
          timer_d = half - TW'(1);
          state_d = StShiftHi;
        end
      end
      StShiftHi: begin
        if (timer_done) begin
          if (bit_q != '0) begin
            bit_d   = bit_q - BW'(1);
            timer_d = half - TW'(1);
            state_d = StShiftLo;
          end else if (idx_q != '0) begin
            idx_d   = idx_q - IW'(1);
            state_d = StFetch;
          end else begin
            timer_d = (half << 1) - TW'(1);
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (timer_done) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        idx_d   = LastPad;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop
  always_comb begin
    busy_d = 1'b1;
    done_d = 1'b0;
    sclk_d = 1'b0;
    load_d = 1'b0;
    srn_d  = 1'b1;
    sdat_d = sdat_q;
    unique case (state_d)
      StIdle: begin
        busy_d = 1'b0;
        sdat_d = 1'b0;
      end
      StChainRst: srn_d  = 1'b0;
      StShiftLo:  sdat_d = sr_d[bit_d];
      StShiftHi:  sclk_d = 1'b1;
      StLoad:     load_d = 1'b1;
      StFinish:   done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sclk_q <= 1'b0;
      sdat_q <= 1'b0;
      load_q <= 1'b0;
      srn_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      sclk_q <= sclk_d;
      sdat_q <= sdat_d;
      load_q <= load_d;
      srn_q  <= srn_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_idx       = idx_q;
  assign serial_clock  = sclk_q;
  assign serial_data   = sdat_q;
  assign serial_load   = load_q;
  assign serial_resetn = srn_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Scoreboard bench for gpio_serial_loader: a small (2-pad, div 1) and a default instance.
module tb_gpio_serial_loader;

  localparam int CB   = 13;
  localparam int NP_S = 2;
  localparam int CD_S = 1;
  localparam int NP_D = 38;
  localparam int CD_D = 4;

  logic clock  = 1'b0;
  logic resetb = 1'b0;
  always #5 clock = ~clock;

  logic start_s = 1'b0, start_d = 1'b0;
  logic busy_s, done_s, sclk_s, sdat_s, load_s, srn_s;
  logic busy_d, done_d, sclk_d, sdat_d, load_d, srn_d;
  logic [0:0]    idx_s;
  logic [5:0]    idx_d;
  logic [CB-1:0] cfg_s, cfg_d;
  logic [CB-1:0] mem_s [NP_S];
  logic [CB-1:0] mem_d [NP_D];
`ifdef GPIO_SERIAL_LOADER_RT_DIV_EN
  logic [7:0] clk_div_s = 8'd0;
`endif

  // Synchronous config stores
  always @(posedge clock) begin
    cfg_s <= mem_s[idx_s];
    cfg_d <= mem_d[idx_d];
  end

  gpio_serial_loader #(.NUM_PADS(NP_S), .CFG_BITS(CB), .CLK_DIV(CD_S)) u_small (
    .clock        (clock),
    .resetb       (resetb),
`ifdef GPIO_SERIAL_LOADER_RT_DIV_EN
    .clk_div      (clk_div_s),
`endif
    .start        (start_s),
    .busy         (busy_s),
    .done         (done_s),
    .cfg_idx      (idx_s),
    .cfg_data     (cfg_s),
    .serial_clock (sclk_s),
    .serial_data  (sdat_s),
    .serial_load  (load_s),
    .serial_resetn(srn_s)
  );

  gpio_serial_loader u_dut (
    .clock        (clock),
    .resetb       (resetb),
`ifdef GPIO_SERIAL_LOADER_RT_DIV_EN
    .clk_div      (8'd4),
`endif
    .start        (start_d),
    .busy         (busy_d),
    .done         (done_d),
    .cfg_idx      (idx_d),
    .cfg_data     (cfg_d),
    .serial_clock (sclk_d),
    .serial_data  (sdat_d),
    .serial_load  (load_d),
    .serial_resetn(srn_d)
  );

  logic m_sclk [2], m_sdat [2], m_load [2], m_busy [2], m_done [2];
  assign m_sclk[0] = sclk_s;  assign m_sclk[1] = sclk_d;
  assign m_sdat[0] = sdat_s;  assign m_sdat[1] = sdat_d;
  assign m_load[0] = load_s;  assign m_load[1] = load_d;
  assign m_busy[0] = busy_s;  assign m_busy[1] = busy_d;
  assign m_done[0] = done_s;  assign m_done[1] = done_d;

  typedef struct {
    int edges;
    int busy;
    int load;
  } rec_t;

  logic [CB-1:0] expw_s [$], expw_d [$];
  rec_t          exprec_s [$], exprec_d [$];

  int n_vec = 0;
  int n_bad = 0;

  int            edges [2], blen [2], llen [2], viol [2], nbits [2];
  logic [CB-1:0] acc [2];
  logic          psclk [2], pdat [2];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_word(input int k, input logic [CB-1:0] w);
    logic [CB-1:0] e;
    int have;
    have = (k == 0) ? expw_s.size() : expw_d.size();
    if (have == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL word[%0d]: got %h expected no word", k, w);
    end else begin
      if (k == 0) e = expw_s.pop_front();
      else        e = expw_d.pop_front();
      n_vec++;
      if (w != e) begin
        n_bad++;
        $display("FAIL word[%0d]: got %h expected %h", k, w, e);
      end
    end
  endtask

  task automatic cmp_rec(input int k);
    rec_t r;
    int have;
    have = (k == 0) ? exprec_s.size() : exprec_d.size();
    if (have == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL done[%0d]: got unexpected done pulse expected none", k);
    end else begin
      if (k == 0) r = exprec_s.pop_front();
      else        r = exprec_d.pop_front();
      chk($sformatf("edges[%0d]", k), edges[k], r.edges);
      chk($sformatf("busy_len[%0d]", k), blen[k], r.busy);
      chk($sformatf("load_len[%0d]", k), llen[k], r.load);
      chk($sformatf("timing_viol[%0d]", k), viol[k], 0);
      chk($sformatf("partial_bits[%0d]", k), nbits[k], 0);
    end
  endtask

  // Monitor: chain model plus per-sequence counters, sampled on the falling edge
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetb) begin
        edges[k] = 0; blen[k] = 0; llen[k] = 0; viol[k] = 0; nbits[k] = 0;
        acc[k] = '0; psclk[k] = 1'b0; pdat[k] = 1'b0;
      end else begin
        if (m_sclk[k] && !psclk[k]) begin
          edges[k]++;
          if (m_sdat[k] != pdat[k]) viol[k]++;
          acc[k] = {acc[k][CB-2:0], m_sdat[k]};
          nbits[k]++;
          if (nbits[k] == CB) begin
            nbits[k] = 0;
            cmp_word(k, acc[k]);
          end
        end else if (m_sclk[k] && psclk[k] && (m_sdat[k] != pdat[k])) begin
          viol[k]++;
        end
        if (m_busy[k]) blen[k]++;
        if (m_load[k]) begin
          llen[k]++;
          if (m_sclk[k]) viol[k]++;
        end
        if (m_done[k]) begin
          cmp_rec(k);
          edges[k] = 0; blen[k] = 0; llen[k] = 0; viol[k] = 0; nbits[k] = 0;
        end
        psclk[k] = m_sclk[k];
        pdat[k]  = m_sdat[k];
      end
    end
  end

  task automatic push_run(input int k, input int h);
    rec_t r;
    int np;
    np = (k == 0) ? NP_S : NP_D;
    for (int i = np - 1; i >= 0; i--) begin
      if (k == 0) expw_s.push_back(mem_s[i]);
      else        expw_d.push_back(mem_d[i]);
    end
    r.edges = np * CB;
    r.busy  = 4 * h + np * (2 + 2 * h * CB) + 1;
    r.load  = 2 * h;
    if (k == 0) exprec_s.push_back(r);
    else        exprec_d.push_back(r);
  endtask

  task automatic pulse_start(input int k);
    @(negedge clock);
    if (k == 0) start_s = 1'b1; else start_d = 1'b1;
    @(negedge clock);
    if (k == 0) start_s = 1'b0; else start_d = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    int n;
    n = 0;
    while (!m_done[k] && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!m_done[k]) chk($sformatf("done_timeout[%0d]", k), 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_srn_s"}, int'(srn_s), 0);
    chk({tag, "_busy_s"}, int'(busy_s), 0);
    chk({tag, "_sclk_s"}, int'(sclk_s), 0);
    chk({tag, "_idx_s"}, int'(idx_s), NP_S - 1);
    chk({tag, "_srn_d"}, int'(srn_d), 0);
    chk({tag, "_busy_d"}, int'(busy_d), 0);
    chk({tag, "_sclk_d"}, int'(sclk_d), 0);
    chk({tag, "_idx_d"}, int'(idx_d), NP_D - 1);
    chk({tag, "_done_d"}, int'(done_d), 0);
    chk({tag, "_load_d"}, int'(load_d), 0);
    chk({tag, "_sdat_d"}, int'(sdat_d), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    mem_s[1] = 13'h1ABC;
    mem_s[0] = 13'h0F0F;
    for (int i = 0; i < NP_D; i++) mem_d[i] = 13'h1803;

    // Reset values and release
    repeat (3) @(negedge clock);
    chk_reset_vals("rst");
    resetb = 1'b1;
    @(negedge clock);
    chk("srn_after_release_s", int'(srn_s), 1);
    chk("srn_after_release_d", int'(srn_d), 1);
    chk("busy_after_release_d", int'(busy_d), 0);

    // Two-pad chain, half-period 1: 61 busy cycles
    push_run(0, CD_S);
    pulse_start(0);
    wait_done(0, 200);
    @(negedge clock);
    chk("done_one_pulse_s", int'(done_s), 0);
    chk("busy_clear_s", int'(busy_s), 0);

`ifdef GPIO_SERIAL_LOADER_RT_DIV_EN
    clk_div_s = 8'd0;
    push_run(0, 1);
    pulse_start(0);
    wait_done(0, 200);
    clk_div_s = 8'd3;
    push_run(0, 3);
    pulse_start(0);
    repeat (20) @(negedge clock);
    clk_div_s = 8'd1;
    wait_done(0, 400);
    @(negedge clock);
`endif

    // Default chain, all words 13'h1803; stray starts in SHIFT_HI and on FINISH
    push_run(1, CD_D);
    pulse_start(1);
    n = 0;
    while (!sclk_d && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("reach_shift_hi", int'(sclk_d), 1);
    start_d = 1'b1;
    @(negedge clock);
    start_d = 1'b0;
    wait_done(1, 5000);
    start_d = 1'b1;
    @(negedge clock);
    start_d = 1'b0;
    repeat (30) @(negedge clock);
    chk("start_on_finish_ignored", int'(busy_d), 0);

    // Abort in the middle of pad 20, then a full reload with distinct words
    for (int i = 0; i < NP_D; i++) mem_d[i] = 13'((i * 291) ^ 13'h0A5A);
    push_run(1, CD_D);
    pulse_start(1);
    n = 0;
    while (!(idx_d == 6'd20 && sclk_d) && n < 4000) begin
      @(negedge clock);
      n++;
    end
    chk("reach_pad20", int'(idx_d), 20);
    #2;
    resetb = 1'b0;
    expw_d.delete();
    exprec_d.delete();
    #1;
    chk_reset_vals("abort");
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("no_load_in_reset", int'(load_d), 0);
    end
    resetb = 1'b1;
    @(negedge clock);
    push_run(1, CD_D);
    pulse_start(1);
    wait_done(1, 5000);

    repeat (5) @(negedge clock);
    chk("words_left_s", expw_s.size(), 0);
    chk("words_left_d", expw_d.size(), 0);
    chk("recs_left_s", exprec_s.size(), 0);
    chk("recs_left_d", exprec_d.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_serial_loader.md
Name: gpio_serial_loader

Overview:
Sequencer that programs the per-pad configuration of the user project GPIO pads (the mprj_io_* control signals) through the daisy-chained serial configuration shift chain. On a start request it resets the chain, fetches one CFG_BITS-wide word per pad from a synchronous config store, shifts all words out MSB-first with a generated serial clock, then pulses the load strobe so every pad latches its new configuration at once. It sits in the management domain between the housekeeping register bank and the pad control chain.

Parameters:
NUM_PADS, 38, number of pads in the chain (equals MPRJ_IO_PADS)
CFG_BITS, 13, configuration bits per pad
CLK_DIV, 4, serial clock half-period in clock cycles (>=1)

Ports:
clock  input  1  core clock
resetb  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a full chain load
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle pulse when the load sequence completes
cfg_idx  output  $clog2(NUM_PADS)  pad index being fetched from config store
cfg_data  input  CFG_BITS  config word for cfg_idx, valid 1 cycle after cfg_idx changes
serial_clock  output  1  chain shift clock
serial_data  output  1  chain serial data
serial_load  output  1  chain parallel-load strobe
serial_resetn  output  1  chain reset, active low

Behaviour:
- One clock domain (clock); reset asynchronous, active-low (resetb). All outputs registered.
- Reset values: busy=0, done=0, cfg_idx=NUM_PADS-1, serial_clock=0, serial_data=0, serial_load=0, serial_resetn=0. First cycle after reset release: IDLE, serial_resetn=1.
- States: IDLE, CHAIN_RST, FETCH, WAIT, SHIFT_LO, SHIFT_HI, LOAD, FINISH.
- IDLE: start=1 -> CHAIN_RST, busy=1 next cycle. start ignored while busy.
- CHAIN_RST: serial_resetn=0 for 2*CLK_DIV cycles; cfg_idx=NUM_PADS-1; -> FETCH.
- FETCH (1 cycle, cfg_idx stable) -> WAIT (1 cycle); at end of WAIT cfg_data captured into shift register, bit counter=CFG_BITS-1 -> SHIFT_LO.
- SHIFT_LO: serial_clock=0, serial_data=shift[bit], held CLK_DIV cycles -> SHIFT_HI.
- SHIFT_HI: serial_clock=1, serial_data unchanged, CLK_DIV cycles. Then: bit>0 -> bit-1, SHIFT_LO; bit==0 and cfg_idx>0 -> cfg_idx-1, FETCH; bit==0 and cfg_idx==0 -> LOAD.
- Order: pad NUM_PADS-1 first, pad 0 last; each word MSB first. Data changes only while serial_clock=0 (setup >= CLK_DIV cycles before rising edge).
- LOAD: serial_clock=0, serial_load=1 for 2*CLK_DIV cycles -> FINISH.
- FINISH: done=1 one cycle, busy=0, cfg_idx reset to NUM_PADS-1 -> IDLE.
- Busy length = 4*CLK_DIV + NUM_PADS*(2 + 2*CLK_DIV*CFG_BITS) + 1 cycles (from first busy cycle through FINISH).
- Exactly NUM_PADS*CFG_BITS serial_clock rising edges per load.
- start coincident with FINISH: ignored. Reset mid-sequence: all outputs to reset values immediately; no partial serial_load ever issued.
- Counters sized from parameters; no wrap: cfg_idx decrements only from >0.

Optional Feature:
Macro GPIO_SERIAL_LOADER_RT_DIV_EN. Defined: adds input port clk_div[7:0]; half-period = clk_div sampled on start acceptance (value 0 treated as 1), held constant for the sequence. Undefined: port absent, half-period = CLK_DIV parameter.

Test Plan:
- Reset: hold resetb low -> serial_resetn=0, busy=0, serial_clock=0, cfg_idx=NUM_PADS-1; release -> serial_resetn=1 next cycle.
- NUM_PADS=2, CFG_BITS=13, CLK_DIV=1, cfg words pad1=13'h1ABC, pad0=13'h0F0F; start -> chain model captures 26 bits 1ABC then 0F0F MSB-first; busy exactly 61 cycles; done one pulse.
- Default params, all cfg_data=13'h1803: 494 serial_clock rising edges; serial_load high 8 cycles after last edge, serial_clock low throughout.
- start pulsed during SHIFT_HI and on FINISH cycle -> ignored; only one done pulse, edge count unchanged.
- resetb asserted mid-shift of pad 20 -> outputs at reset values same cycle, no serial_load pulse; new start runs full 494-edge sequence.
- With GPIO_SERIAL_LOADER_RT_DIV_EN, clk_div=0 then clk_div=3 -> half-periods 1 and 3 cycles; changing clk_div mid-sequence has no effect.
